// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue between MEM and the register file / CSR unit.
// Buffers up to DEPTH completed instructions, retires the head, and flushes on exception or ertn.
module wb_commit_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int NEXC   = 6,
  parameter logic [NEXC*6-1:0] ECODE_TABLE = {6'h00, 6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08}
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_allowin,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [DATA_W-1:0]         in_vaddr,
  input  logic                      in_rf_we,
  input  logic [4:0]                in_rf_waddr,
  input  logic [DATA_W-1:0]         in_rf_wdata,
  input  logic                      in_csr_re,
  input  logic                      in_csr_we,
  input  logic [13:0]               in_csr_num,
  input  logic [DATA_W-1:0]         in_csr_wmask,
  input  logic [DATA_W-1:0]         in_csr_wvalue,
  input  logic [NEXC-1:0]           in_exc,
  input  logic                      in_ertn,
  input  logic                      commit_ready,
  input  logic [DATA_W-1:0]         csr_rvalue,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [13:0]               csr_num,
  output logic                      csr_we,
  output logic [DATA_W-1:0]         csr_wmask,
  output logic [DATA_W-1:0]         csr_wvalue,
  output logic                      exc_signal,
  output logic                      ertn_signal,
  output logic [5:0]                wb_ecode,
  output logic [8:0]                wb_esubcode,
  output logic [DATA_W-1:0]         wb_pc,
  output logic [DATA_W-1:0]         wb_vaddr,
  output logic [31:0]               pending_mask,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [DATA_W-1:0]         debug_wb_pc,
  output logic [3:0]                debug_wb_rf_we,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] vaddr;
    logic              rf_we;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              csr_re;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] wvalue;
    logic [NEXC-1:0]   exc;
    logic              ertn;
  } entry_t;

  // Lowest-index set flag wins.
  function automatic logic [5:0] ecode_of(input logic [NEXC-1:0] exc);
    logic [5:0] e;
    e = '0;
    for (int i = NEXC - 1; i >= 0; i--) begin
      if (exc[i]) e = ECODE_TABLE[6*i +: 6];
    end
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          head;
  entry_t          in_ent;
  logic            head_valid, head_exc, commit, flush, push, pop;
  logic [PW-1:0]   pidx;
  logic [31:0]     pend;

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign head_exc   = |head.exc;
  assign commit     = head_valid & commit_ready;
  assign flush      = commit & (head_exc | head.ertn);
  assign in_allowin = (count_q < CW'(DEPTH)) & ~flush;
  assign push       = in_valid & in_allowin;
  assign pop        = commit;

  assign in_ent = '{pc: in_pc, vaddr: in_vaddr, rf_we: in_rf_we, waddr: in_rf_waddr,
                    wdata: in_rf_wdata, csr_re: in_csr_re, csr_we: in_csr_we,
                    csr_num: in_csr_num, wmask: in_csr_wmask, wvalue: in_csr_wvalue,
                    exc: in_exc, ertn: in_ertn};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head values are presented whenever valid; write strobes only fire on a plain commit.
  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    csr_num     = '0;
    csr_we      = 1'b0;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    exc_signal  = 1'b0;
    ertn_signal = 1'b0;
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_pc       = '0;
    wb_vaddr    = '0;
    if (head_valid) begin
      rf_waddr   = head.waddr;
      rf_wdata   = head.csr_re ? csr_rvalue : head.wdata;
      csr_num    = head.csr_num;
      csr_wmask  = head.wmask;
      csr_wvalue = head.wvalue;
      wb_pc      = head.pc;
      wb_vaddr   = head.vaddr;
      wb_ecode   = head_exc ? ecode_of(head.exc) : 6'd0;
      if (commit) begin
        if (head_exc) begin
          exc_signal = 1'b1;
        end else if (head.ertn) begin
          ertn_signal = 1'b1;
        end else begin
          rf_we  = head.rf_we & (head.waddr != 5'd0);
          csr_we = head.csr_we;
        end
      end
    end
  end

  always_comb begin
    pend = '0;
    pidx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pidx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && mem_q[pidx].rf_we) pend[mem_q[pidx].waddr] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign pending_mask      = pend;
  assign occupancy         = count_q;
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: queue-based reference model checked every cycle on the falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_wb_commit_queue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int NEXC   = 6;
  localparam logic [NEXC*6-1:0] TBL = {6'h00, 6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [5:0]  exc;
    logic        ertn;
  } ent_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
  } log_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_allowin;
  logic [31:0] in_pc, in_vaddr, in_rf_wdata, in_csr_wmask, in_csr_wvalue;
  logic        in_rf_we, in_csr_re, in_csr_we, in_ertn;
  logic [4:0]  in_rf_waddr;
  logic [13:0] in_csr_num;
  logic [5:0]  in_exc;
  logic        commit_ready;
  logic [31:0] csr_rvalue;
  logic        rf_we, csr_we, exc_signal, ertn_signal;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, csr_wmask, csr_wvalue, wb_pc, wb_vaddr, pending_mask;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [2:0]  occupancy;
  logic [3:0]  debug_wb_rf_we;

  wb_commit_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NEXC(NEXC), .ECODE_TABLE(TBL)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_pc(in_pc), .in_vaddr(in_vaddr), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_rf_wdata(in_rf_wdata), .in_csr_re(in_csr_re), .in_csr_we(in_csr_we),
    .in_csr_num(in_csr_num), .in_csr_wmask(in_csr_wmask), .in_csr_wvalue(in_csr_wvalue),
    .in_exc(in_exc), .in_ertn(in_ertn), .commit_ready(commit_ready), .csr_rvalue(csr_rvalue),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .exc_signal(exc_signal), .ertn_signal(ertn_signal), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .pending_mask(pending_mask), .occupancy(occupancy), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  ent_t q[$];
  log_t wlog[$];
  logic [5:0] ecode_ref [NEXC] = '{6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the queue contents decide every output, then the upcoming edge is applied.
  ent_t        h;
  bit          hv, hx, cm, fl, al, pu, plain;
  logic [5:0]  e_ecode;
  logic [31:0] e_pend;
  ent_t        cur;

  always @(negedge clk) begin
    if (mon_en) begin
      hv = (q.size() > 0);
      h  = hv ? q[0] : '0;
      hx = (h.exc != 6'd0);
      cm = hv && commit_ready;
      fl = cm && (hx || h.ertn);
      al = (q.size() < DEPTH) && !fl;
      plain = cm && !hx && !h.ertn;
      e_ecode = 6'd0;
      for (int i = NEXC - 1; i >= 0; i--) if (h.exc[i]) e_ecode = ecode_ref[i];
      e_pend = 32'd0;
      foreach (q[i]) if (q[i].rf_we) e_pend[q[i].waddr] = 1'b1;
      e_pend[0] = 1'b0;

      chk("in_allowin", in_allowin, al);
      chk("occupancy", occupancy, q.size());
      chk("rf_we", rf_we, plain && h.rf_we && (h.waddr != 0));
      chk("rf_waddr", rf_waddr, h.waddr);
      chk("rf_wdata", rf_wdata, hv ? (h.csr_re ? csr_rvalue : h.wdata) : 32'd0);
      chk("csr_num", csr_num, h.csr_num);
      chk("csr_we", csr_we, plain && h.csr_we);
      chk("csr_wmask", csr_wmask, h.wmask);
      chk("csr_wvalue", csr_wvalue, h.wvalue);
      chk("exc_signal", exc_signal, cm && hx);
      chk("ertn_signal", ertn_signal, cm && !hx && h.ertn);
      chk("wb_ecode", wb_ecode, e_ecode);
      chk("wb_esubcode", wb_esubcode, 9'd0);
      chk("wb_pc", wb_pc, h.pc);
      chk("wb_vaddr", wb_vaddr, h.vaddr);
      chk("pending_mask", pending_mask, e_pend);
      chk("debug_pc", debug_wb_pc, h.pc);
      chk("debug_we", debug_wb_rf_we, {4{plain && h.rf_we && (h.waddr != 0)}});
      chk("debug_wnum", debug_wb_rf_wnum, h.waddr);
      chk("debug_wdata", debug_wb_rf_wdata, hv ? (h.csr_re ? csr_rvalue : h.wdata) : 32'd0);

      if (rf_we === 1'b1) wlog.push_back('{rf_waddr, rf_wdata, cyc});

      cur = '{pc: in_pc, vaddr: in_vaddr, rf_we: in_rf_we, waddr: in_rf_waddr,
              wdata: in_rf_wdata, csr_re: in_csr_re, csr_we: in_csr_we, csr_num: in_csr_num,
              wmask: in_csr_wmask, wvalue: in_csr_wvalue, exc: in_exc, ertn: in_ertn};
      pu = in_valid && al;
      if (!resetn || fl) begin
        q.delete();
      end else begin
        if (cm) void'(q.pop_front());
        if (pu) q.push_back(cur);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [4:0] wa, input logic [31:0] wd);
    ent_t e;
    e = '0;
    e.pc    = 32'h1c00_0000 + {25'd0, wa, 2'd0};
    e.vaddr = 32'h8000_0000 | wd;
    e.rf_we = 1'b1;
    e.waddr = wa;
    e.wdata = wd;
    return e;
  endfunction

  task automatic set_in(input ent_t e);
    in_pc = e.pc; in_vaddr = e.vaddr; in_rf_we = e.rf_we; in_rf_waddr = e.waddr;
    in_rf_wdata = e.wdata; in_csr_re = e.csr_re; in_csr_we = e.csr_we;
    in_csr_num = e.csr_num; in_csr_wmask = e.wmask; in_csr_wvalue = e.wvalue;
    in_exc = e.exc; in_ertn = e.ertn;
  endtask

  task automatic send(input ent_t e);
    int n;
    set_in(e);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_allowin && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_allowin) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_allowin=%0b required 1", in_allowin);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (occupancy != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain_timeout", occupancy, 0);
    tick();
  endtask

  ent_t e;
  int   found;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; commit_ready = 1'b0; csr_rvalue = 32'd0;
    set_in('0);
    tick();
    mon_en = 1'b1;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_allowin", in_allowin, 1);
    chk("rst_wb_pc", wb_pc, 0);
    tick();

    // Three back-to-back writes retire one per cycle, in order.
    commit_ready = 1'b1;
    wlog.delete();
    send(mk(5'd1, 32'h11));
    send(mk(5'd2, 32'h22));
    send(mk(5'd3, 32'h33));
    wait_empty();
    chk("t1_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t1_w0", {wlog[0].waddr, wlog[0].wdata}, {5'd1, 32'h11});
      chk("t1_w1", {wlog[1].waddr, wlog[1].wdata}, {5'd2, 32'h22});
      chk("t1_w2", {wlog[2].waddr, wlog[2].wdata}, {5'd3, 32'h33});
      chk("t1_gap01", wlog[1].cyc - wlog[0].cyc, 1);
      chk("t1_gap12", wlog[2].cyc - wlog[1].cyc, 1);
    end

    // Fill, hold a fifth, then release.
    commit_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(5'(7 + i), 32'h70 + i));
    set_in(mk(5'd11, 32'h75));
    in_valid = 1'b1;
    commit_ready = 1'b1;
    @(negedge clk);
    chk("t2_full_occ", occupancy, 4);
    chk("t2_full_allowin", in_allowin, 0);
    @(negedge clk);
    chk("t2_after_pop_occ", occupancy, 3);
    chk("t2_after_pop_allowin", in_allowin, 1);
    tick();
    in_valid = 1'b0;
    wait_empty();

    // Exception in the middle flushes the younger entry.
    commit_ready = 1'b0;
    wlog.delete();
    send(mk(5'd5, 32'h55));
    e = mk(5'd12, 32'hBB); e.exc = 6'b001100; e.pc = 32'h1c00_0010; e.vaddr = 32'h0000_1234;
    send(e);
    send(mk(5'd6, 32'h66));
    commit_ready = 1'b1;
    @(negedge clk);
    chk("t3_a_waddr", rf_waddr, 5);
    @(negedge clk);
    chk("t3_exc", exc_signal, 1);
    chk("t3_ecode", wb_ecode, 6'h0B);
    chk("t3_pc", wb_pc, 32'h1c00_0010);
    chk("t3_rf_we", rf_we, 0);
    chk("t3_allowin", in_allowin, 0);
    @(negedge clk);
    chk("t3_occ", occupancy, 0);
    chk("t3_exc_off", exc_signal, 0);
    found = 0;
    foreach (wlog[i]) if (wlog[i].waddr == 5'd6) found++;
    chk("t3_c_not_written", found, 0);
    tick();

    // ertn alone, then ertn together with an exception.
    e = mk(5'd9, 32'h99); e.ertn = 1'b1; e.csr_we = 1'b1;
    send(e);
    wait_empty();
    e = mk(5'd9, 32'h9A); e.ertn = 1'b1; e.exc = 6'b100001;
    commit_ready = 1'b0;
    send(e);
    commit_ready = 1'b1;
    @(negedge clk);
    chk("t3_prio_exc", exc_signal, 1);
    chk("t3_prio_ertn", ertn_signal, 0);
    chk("t3_prio_ecode", wb_ecode, 6'h08);
    tick();

    // CSR read-through and CSR write.
    csr_rvalue = 32'hABCD;
    commit_ready = 1'b0;
    e = mk(5'd8, 32'hDEAD); e.csr_re = 1'b1; e.csr_num = 14'h5;
    send(e);
    @(negedge clk);
    chk("t4_csr_num", csr_num, 14'h5);
    chk("t4_idle_rf_we", rf_we, 0);
    tick();
    commit_ready = 1'b1;
    @(negedge clk);
    chk("t4_rf_we", rf_we, 1);
    chk("t4_rf_wdata", rf_wdata, 32'hABCD);
    tick();
    commit_ready = 1'b0;
    e = '0; e.csr_we = 1'b1; e.csr_num = 14'h6; e.wmask = 32'hF; e.wvalue = 32'h3;
    send(e);
    @(negedge clk);
    chk("t4_csr_we_idle", csr_we, 0);
    tick();
    commit_ready = 1'b1;
    @(negedge clk);
    chk("t4_csr_we", csr_we, 1);
    chk("t4_csr_wmask", csr_wmask, 32'hF);
    chk("t4_csr_wvalue", csr_wvalue, 32'h3);
    @(negedge clk);
    chk("t4_csr_we_after", csr_we, 0);
    tick();

    // Pending mask ignores r0.
    commit_ready = 1'b0;
    send(mk(5'd0, 32'h1));
    send(mk(5'd4, 32'h4));
    send(mk(5'd31, 32'h1F));
    @(negedge clk);
    chk("t5_pending", pending_mask, 32'h8000_0010);
    tick();
    commit_ready = 1'b1;
    wait_empty();
    @(negedge clk);
    chk("t5_pending_clear", pending_mask, 32'h0);
    tick();

    // Reset with entries queued and a push offered.
    commit_ready = 1'b0;
    send(mk(5'd13, 32'hD1));
    send(mk(5'd14, 32'hD2));
    send(mk(5'd15, 32'hD3));
    resetn = 1'b0;
    set_in(mk(5'd16, 32'hD4));
    in_valid = 1'b1;
    tick();
    resetn = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_occ", occupancy, 0);
    chk("t6_allowin", in_allowin, 1);
    chk("t6_pending", pending_mask, 0);
    chk("t6_wb_pc", wb_pc, 0);
    chk("t6_rf_wdata", rf_wdata, 0);
    tick();

    // Long burst with continuous commit exercises pointer wrap.
    commit_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(mk(5'(17 + i), 32'h100 + i));
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
